fxp_mult_pipe: RTL

- Pipelined, parametrised signed two's-complement fixed-point multiplier for the CWT datapath.
- Successor to the combinational sign-magnitude multiplier:
  - configurable latency
  - valid/ready flow control with backpressure
  - selectable truncate/round mode
  - overflow detection, with optional saturation
- Sits between the wavelet-coefficient ROM / sample buffer and the accumulator stage.

---
 rtl/fxp_mult_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fxp_mult_pipe.sv
// Pipelined signed fixed-point multiplier with valid/ready flow control.
// Define FXP_MULT_SAT_EN to saturate mul_out on overflow instead of wrapping.
module fxp_mult_pipe #(
  parameter int BITS  = 16,
  parameter int TRANC = 8,
  parameter int LAT   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] mul_in1,
  input  logic [BITS-1:0] mul_in2,
  input  logic            rnd_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] mul_out,
  output logic            ovf
);

  localparam int PW = 2 * BITS;
  localparam int MW = PW - TRANC + 1;
  localparam int D  = LAT - 2;

  localparam logic [MW-1:0] LIM_POS =
    {{(MW-BITS+1){1'b0}}, {(BITS-1){1'b1}}};
  localparam logic [MW-1:0] LIM_NEG = LIM_POS + MW'(1);
  localparam logic [BITS-1:0] SAT_MAX = {1'b0, {(BITS-1){1'b1}}};
  localparam logic [BITS-1:0] SAT_MIN = {1'b1, {(BITS-1){1'b0}}};

  generate
    if (LAT < 2 || LAT > 6) begin : g_bad_lat
      $error("fxp_mult_pipe: LAT must be in 2..6");
    end
    if (TRANC < 1 || TRANC >= BITS) begin : g_bad_tranc
      $error("fxp_mult_pipe: TRANC must be in 1..BITS-1");
    end
  endgenerate

  function automatic logic [BITS-1:0] mag(input logic [BITS-1:0] x);
    return x[BITS-1] ? (~x + BITS'(1)) : x;
  endfunction

  logic en;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;

  logic            s1_v;
  logic            s1_sgn;
  logic            s1_rnd;
  logic [BITS-1:0] s1_ma;
  logic [BITS-1:0] s1_mb;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_v   <= 1'b0;
      s1_sgn <= 1'b0;
      s1_rnd <= 1'b0;
      s1_ma  <= '0;
      s1_mb  <= '0;
    end else if (en) begin
      s1_v   <= in_valid;
      s1_sgn <= mul_in1[BITS-1] ^ mul_in2[BITS-1];
      s1_rnd <= rnd_mode;
      s1_ma  <= mag(mul_in1);
      s1_mb  <= mag(mul_in2);
    end
  end

  // Only P[PW-1:TRANC-1] matters downstream; bit 0 here is the round bit.
  logic [MW-1:0] p_hi;
  assign p_hi = MW'(({{BITS{1'b0}}, s1_ma} * {{BITS{1'b0}}, s1_mb})
                    >> (TRANC - 1));

  logic          f_v;
  logic          f_sgn;
  logic          f_rnd;
  logic [MW-1:0] f_p;

  generate
    if (D <= 0) begin : g_nodly
      assign f_v   = s1_v;
      assign f_sgn = s1_sgn;
      assign f_rnd = s1_rnd;
      assign f_p   = p_hi;
    end else begin : g_dly
      logic          c_v   [1:D];
      logic          c_sgn [1:D];
      logic          c_rnd [1:D];
      logic [MW-1:0] c_p   [1:D];

      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int k = 1; k <= D; k++) begin
            c_v[k]   <= 1'b0;
            c_sgn[k] <= 1'b0;
            c_rnd[k] <= 1'b0;
            c_p[k]   <= '0;
          end
        end else if (en) begin
          c_v[1]   <= s1_v;
          c_sgn[1] <= s1_sgn;
          c_rnd[1] <= s1_rnd;
          c_p[1]   <= p_hi;
          for (int k = 2; k <= D; k++) begin
            c_v[k]   <= c_v[k-1];
            c_sgn[k] <= c_sgn[k-1];
            c_rnd[k] <= c_rnd[k-1];
            c_p[k]   <= c_p[k-1];
          end
        end
      end

      assign f_v   = c_v[D];
      assign f_sgn = c_sgn[D];
      assign f_rnd = c_rnd[D];
      assign f_p   = c_p[D];
    end
  endgenerate

  logic [MW-1:0]   m;
  logic            ovf_c;
  logic [BITS-1:0] res;

  always_comb begin
    m     = {1'b0, f_p[MW-1:1]} + {{(MW-1){1'b0}}, f_rnd & f_p[0]};
    ovf_c = f_sgn ? (m > LIM_NEG) : (m > LIM_POS);
    res   = f_sgn ? (~m[BITS-1:0] + BITS'(1)) : m[BITS-1:0];
`ifdef FXP_MULT_SAT_EN
    if (ovf_c) begin
      res = f_sgn ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      mul_out   <= '0;
      ovf       <= 1'b0;
    end else if (en) begin
      out_valid <= f_v;
      mul_out   <= res;
      ovf       <= ovf_c;
    end
  end

endmodule
